tt_input_debounce: RTL

Input-conditioning stage placed directly upstream of the Tiny Tapeout user design.
- Takes the raw 8-bit slide-switch/push-button bus (`ui_in`) and synchronises every bit to `clk`.
- Debounces each bit independently and produces clean levels plus single-cycle rise/fall pulses.
- The user design consumes these in place of raw `ui_in`, e.g. to step the 7-segment display logic.

---
 rtl/tt_debounce_pkg.sv | 18 +
 rtl/tt_debounce_bit.sv | 86 ++++++++
 rtl/tt_input_debounce.sv | 62 ++++++
 3 files changed

// File: rtl/tt_debounce_pkg.sv
// Shared defaults, counter-width helper and counter type for the input debouncer.
// Optional feature macro: TT_DEBOUNCE_TOGGLE_EN (adds per-bit toggle outputs).
package tt_debounce_pkg;

  localparam int DEF_WIDTH         = 8;
  localparam int DEF_STABLE_CYCLES = 4;
  localparam int DEF_PRESCALE      = 1;

  // Enough bits to hold 0..stable_cycles, never narrower than one bit.
  function automatic int cnt_width(input int stable_cycles);
    return (stable_cycles < 1) ? 1 : $clog2(stable_cycles + 1);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_STABLE_CYCLES);

  typedef logic [DEF_CNT_W-1:0] db_cnt_t;

endpackage

// File: rtl/tt_debounce_bit.sv
// One input bit: two-flop synchroniser, stability counter, debounced level and edge pulses.
// Optional feature macro: TT_DEBOUNCE_TOGGLE_EN (adds the toggle register).
module tt_debounce_bit
  import tt_debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic ena,
  input  logic tick,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall
`ifdef TT_DEBOUNCE_TOGGLE_EN
  ,
  output logic toggle
`endif
);

  localparam int             CNT_W = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             commit;

  // The synchroniser runs free of enable and tick so it never holds stale data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= RESET_VAL;
      sync2 <= RESET_VAL;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Any clock where the synchronised input agrees with the level restarts the count.
  always_comb begin
    cnt_next = '0;
    commit   = 1'b0;
    if (ena && (sync2 != db)) begin
      if (!tick) begin
        cnt_next = cnt;
      end else if (cnt == LAST) begin
        commit = 1'b1;
      end else begin
        cnt_next = cnt + ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db   <= RESET_VAL;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      rise <= commit & sync2;
      fall <= commit & ~sync2;
      if (commit) begin
        db <= sync2;
      end
    end
  end

`ifdef TT_DEBOUNCE_TOGGLE_EN
  // Flips on the same edge that launches the rise pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      toggle <= 1'b0;
    end else if (commit && sync2) begin
      toggle <= ~toggle;
    end
  end
`endif

endmodule

// File: rtl/tt_input_debounce.sv
// Tiny Tapeout input conditioner: shared debounce prescaler feeding WIDTH independent bit debouncers.
// Optional feature macro: TT_DEBOUNCE_TOGGLE_EN (adds the toggle output bus).
module tt_input_debounce
  import tt_debounce_pkg::*;
#(
  parameter int               WIDTH         = DEF_WIDTH,
  parameter int               STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int               PRESCALE      = DEF_PRESCALE,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`ifdef TT_DEBOUNCE_TOGGLE_EN
  ,
  output logic [WIDTH-1:0] toggle
`endif
);

  localparam int               PRE_W    = $clog2(PRESCALE + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

  logic [PRE_W-1:0] pre;
  logic             tick;

  assign tick = ena && (pre == PRE_LAST);

  // Prescaler phase is frozen while disabled so a pause does not shorten the next tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre <= '0;
    end else if (ena) begin
      pre <= (pre == PRE_LAST) ? '0 : pre + PRE_ONE;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tt_debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .RESET_VAL    (RESET_VAL[i])
    ) u_bit (
      .clk   (clk),
      .reset (reset),
      .ena   (ena),
      .tick  (tick),
      .raw   (raw_in[i]),
      .db    (db_out[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
`ifdef TT_DEBOUNCE_TOGGLE_EN
      ,
      .toggle(toggle[i])
`endif
    );
  end

endmodule
